// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared limits, default divisors and configuration check for the divider chain
package clkdiv_pkg;
  localparam int NCH_MAX = 8;
  localparam int CW_MIN = 2;
  localparam int CW_MAX = 32;
  localparam int CHW = $clog2(NCH_MAX);
  localparam int DIV0_DEF = 5000;
  localparam int DIVN_DEF = 10;
  function automatic bit cfg_ok(input int nch, input int cw);
    return nch >= 1 && nch <= NCH_MAX && cw >= CW_MIN && cw <= CW_MAX;
  endfunction
endpackage

// File: rtl/clkdiv_chain_if.sv
// clkdiv_chain_if: control/write inputs and per-stage tick/clock outputs of the divider chain
interface clkdiv_chain_if
  import clkdiv_pkg::*;
#(
  parameter int NCH = 2,
  parameter int CW = 13
);
  logic en;
  logic sync;
  logic wr_en;
  logic [CHW-1:0] wr_ch;
  logic [CW-1:0] wr_div;
  logic [NCH-1:0] tick_o;
  logic [NCH-1:0] clk_o;
  modport master(output en, sync, wr_en, wr_ch, wr_div, input tick_o, clk_o);
  modport slave(input en, sync, wr_en, wr_ch, wr_div, output tick_o, clk_o);
endinterface

// File: rtl/clkdiv_stage.sv
// clkdiv_stage: one divider stage with shadow divisor, terminal tick and square-wave output
module clkdiv_stage
  import clkdiv_pkg::*;
#(
  parameter int CW = 13,
  parameter logic [CW-1:0] RST_DIV = CW'(DIVN_DEF)
) (
  input  logic          clkin,
  input  logic          clr,
  input  logic          pt,
  input  logic          sync,
  input  logic          wr,
  input  logic [CW-1:0] wr_div,
  output logic          tick,
  output logic          tick_q,
  output logic          clk_q
);
  logic [CW-1:0] cnt, div, pend, cnt_n, div_n, pend_n;
  assign tick = pt && (cnt == div - 1'b1);
  // the shadow divisor only becomes active at a wrap or sync, so a write never cuts a period short
  always_comb begin
    pend_n = wr ? ((wr_div == '0) ? CW'(1) : wr_div) : pend;
    cnt_n = (sync || tick) ? '0 : (pt ? cnt + 1'b1 : cnt);
    div_n = (sync || tick) ? pend_n : div;
  end
  always_ff @(posedge clkin) begin
    if (clr) begin
      cnt <= '0;
      div <= RST_DIV;
      pend <= RST_DIV;
      tick_q <= 1'b0;
      clk_q <= 1'b1;
    end else begin
      cnt <= cnt_n;
      div <= div_n;
      pend <= pend_n;
      tick_q <= tick && !sync;
      clk_q <= {1'b0, cnt_n} < (({1'b0, div_n} + 1'b1) >> 1);
    end
  end
endmodule

// File: rtl/clkdiv_chain.sv
// clkdiv_chain: NCH cascaded programmable dividers; each stage counts the terminal ticks of the one before
module clkdiv_chain
  import clkdiv_pkg::*;
#(
  parameter int NCH = 2,
  parameter int CW = 13,
  parameter int DIV0 = DIV0_DEF,
  parameter int DIVN = DIVN_DEF
) (
  input logic clkin,
  input logic clr,
  clkdiv_chain_if.slave bus
);
  logic [NCH-1:0] pt, nx, tick_r, clk_r;
  assign pt = NCH'({nx, bus.en});
  assign bus.tick_o = tick_r;
  assign bus.clk_o = clk_r;
  if (!cfg_ok(NCH, CW)) begin : g_bad_cfg
    $error("clkdiv_chain: NCH or CW out of range");
  end
  for (genvar i = 0; i < NCH; i++) begin : g_stage
    clkdiv_stage #(
      .CW(CW),
      .RST_DIV(CW'(i == 0 ? DIV0 : DIVN))
    ) u_stage (
      .clkin(clkin),
      .clr(clr),
      .pt(pt[i]),
      .sync(bus.sync),
      .wr(bus.wr_en && bus.wr_ch == CHW'(i)),
      .wr_div(bus.wr_div),
      .tick(nx[i]),
      .tick_q(tick_r[i]),
      .clk_q(clk_r[i])
    );
  end
endmodule

// File: tb/tb_clkdiv_chain.sv
// tb_clkdiv_chain: directed long-period checks plus a per-cycle vector table for the small-divisor corners
module tb_clkdiv_chain;
  logic clkin = 1'b0;
  logic clr = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  always #10 clkin = ~clkin;

  clkdiv_chain_if #(.NCH(2), .CW(13)) bus ();
  clkdiv_chain #(.NCH(2), .CW(13), .DIV0(5000), .DIVN(10)) dut (
    .clkin(clkin),
    .clr(clr),
    .bus(bus)
  );

  typedef struct {
    logic en, sync, wr;
    logic [2:0] ch;
    logic [12:0] d;
    logic [1:0] tk, ck;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clkin);
    #1;
  endtask

  task automatic drv(input logic e, input logic s, input logic w, input logic [2:0] ch, input logic [12:0] d);
    bus.en = e;
    bus.sync = s;
    bus.wr_en = w;
    bus.wr_ch = ch;
    bus.wr_div = d;
  endtask

  task automatic add(input logic e, input logic s, input logic w, input logic [2:0] ch, input logic [12:0] d,
                     input logic [1:0] tk, input logic [1:0] ck);
    vq.push_back('{e, s, w, ch, d, tk, ck});
  endtask

  task automatic idle(input int n, input logic [1:0] ck);
    for (int i = 0; i < n; i++) add(1, 0, 0, 0, 0, 2'b00, ck);
  endtask

  task automatic wait_tick(input int lim, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.tick_o[0] && n < lim);
  endtask

  initial begin
    int n, t0a, n0, fall0, rise0, fall1, t1, n1, bad;
    logic [6:0] pat;
    drv(0, 0, 0, 0, 0);
    cyc();
    cyc();
    chk("rst_tick", bus.tick_o, 0);
    chk("rst_clk", bus.clk_o, 3);

    // default chain free-running from reset
    clr = 1'b0;
    bus.en = 1'b1;
    t0a = 0; n0 = 0; fall0 = 0; rise0 = 0; fall1 = 0; t1 = 0; n1 = 0;
    for (int t = 1; t <= 50000; t++) begin
      cyc();
      if (bus.tick_o[0]) begin
        n0++;
        if (t0a == 0) t0a = t;
      end
      if (!bus.clk_o[0] && fall0 == 0) fall0 = t;
      if (fall0 != 0 && rise0 == 0 && bus.clk_o[0]) rise0 = t;
      if (!bus.clk_o[1] && fall1 == 0) fall1 = t;
      if (bus.tick_o[1]) begin
        n1++;
        t1 = t;
      end
    end
    chk("tick0_first", t0a, 5000);
    chk("tick0_count", n0, 10);
    chk("clk0_fall", fall0, 2500);
    chk("clk0_rise", rise0, 5000);
    chk("clk1_fall", fall1, 25000);
    chk("tick1_at", t1, 50000);
    chk("tick1_count", n1, 1);
    chk("both_ticks_at_50000", bus.tick_o, 3);
    chk("clk1_back_high", bus.clk_o[1], 1);

    // sync at cnt_0 = 1234
    repeat (1234) cyc();
    bus.sync = 1'b1;
    cyc();
    bus.sync = 1'b0;
    chk("sync_clk0", bus.clk_o[0], 1);
    chk("sync_tick", bus.tick_o, 0);
    wait_tick(6000, n);
    chk("sync_to_tick", n, 5000);

    // 300-cycle pause in the low phase
    repeat (3000) cyc();
    chk("pre_freeze_clk0", bus.clk_o[0], 0);
    bus.en = 1'b0;
    bad = 0;
    repeat (300) begin
      cyc();
      if (bus.clk_o != 2'b10 || bus.tick_o != 2'b00) bad++;
    end
    chk("freeze_bad_cycles", bad, 0);
    bus.en = 1'b1;
    wait_tick(3000, n);
    chk("pause_tick", n, 2000);

    // mid-period write of D=7 to stage 0
    repeat (100) cyc();
    drv(1, 0, 1, 0, 7);
    cyc();
    drv(1, 0, 0, 0, 0);
    wait_tick(6000, n);
    chk("old_period_rest", n, 4899);
    for (int i = 0; i < 7; i++) begin
      cyc();
      pat[i] = bus.clk_o[0];
    end
    chk("d7_clk_pattern", pat, 7'b1000111);
    chk("d7_tick", bus.tick_o[0], 1);

    // per-cycle vectors; stage 0 starts at cnt 0 with divisor 7
    add(1, 1, 1, 1, 0, 2'b00, 2'b11);
    idle(3, 2'b11); idle(3, 2'b10);
    add(1, 0, 0, 0, 0, 2'b11, 2'b11);
    add(1, 0, 1, 5, 2, 2'b00, 2'b11);
    add(1, 1, 0, 0, 0, 2'b00, 2'b11);
    idle(3, 2'b11); idle(3, 2'b10);
    add(1, 0, 0, 0, 0, 2'b11, 2'b11);
    add(0, 0, 0, 0, 0, 2'b00, 2'b11);
    add(0, 0, 1, 0, 3, 2'b00, 2'b11);
    idle(3, 2'b11); idle(3, 2'b10);
    add(1, 0, 0, 0, 0, 2'b11, 2'b11);
    idle(1, 2'b11); idle(1, 2'b10);
    add(1, 0, 0, 0, 0, 2'b11, 2'b11);
    idle(1, 2'b11); idle(1, 2'b10);
    add(1, 0, 1, 0, 2, 2'b11, 2'b11);
    idle(1, 2'b10);
    add(1, 0, 0, 0, 0, 2'b11, 2'b11);
    idle(1, 2'b10);
    add(1, 1, 0, 0, 0, 2'b00, 2'b11);
    idle(1, 2'b10);
    add(1, 0, 0, 0, 0, 2'b11, 2'b11);
    idle(1, 2'b10);
    add(0, 1, 0, 0, 0, 2'b00, 2'b11);
    add(0, 0, 0, 0, 0, 2'b00, 2'b11);
    idle(1, 2'b10);
    add(1, 0, 0, 0, 0, 2'b11, 2'b11);
    foreach (vq[i]) begin
      drv(vq[i].en, vq[i].sync, vq[i].wr, vq[i].ch, vq[i].d);
      cyc();
      chk($sformatf("vec%0d_tick", i), bus.tick_o, vq[i].tk);
      chk($sformatf("vec%0d_clk", i), bus.clk_o, vq[i].ck);
    end

    // clr at the terminal count with a pending write
    drv(0, 0, 0, 0, 0);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_tick", bus.tick_o, 0);
    chk("clr_clk", bus.clk_o, 3);
    bus.en = 1'b1;
    repeat (10) cyc();
    drv(1, 0, 1, 0, 9);
    cyc();
    drv(1, 0, 0, 0, 0);
    repeat (4988) cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_tc_tick", bus.tick_o, 0);
    chk("clr_tc_clk", bus.clk_o, 3);
    wait_tick(6000, n);
    chk("clr_tc_period", n, 5000);
    chk("clr_tc_stage1", bus.tick_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
